dbf_scan_ctrl: RTL and testbench
================================

# dbf_scan_ctrl

Scanline sequencer for the digital beamforming (DBF) channel array. For each scanline it loads the coarse and fine delay LUTs, fires the transmit window, and then opens the receive/beamforming window. It then advances to the next line until the frame is complete. One instance drives the shared `dbf_lut_addr`, `dbf_lut_we`, `tx_en` and `start` inputs of all `dbf_chNN` channels and the apodization/summation stage.

## Interface
- `ADDR_WD`, 8: width of the LUT address bus.
- `LUT_DEPTH`, 256: LUT entries written per line, with 1 ≤ `LUT_DEPTH` ≤ 2^`ADDR_WD`.
- `TX_CYC`, 16: cycles `tx_en` is held high per line, ≥1.
- `RX_SAMPLES`, 2048: receive samples per line, ≥1.
- `SMP_WD`, 12: width of `smp_idx`, with 2^`SMP_WD` ≥ `RX_SAMPLES`.
- `NUM_LINES`, 128: scanlines per frame, ≥1.
- `LINE_WD`, 8: width of `line_idx`, with 2^`LINE_WD` ≥ `NUM_LINES`.
- `clk`, in, 1: 40 MHz system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `scan_go`, in, 1: single-cycle pulse that starts a frame; sampled only in IDLE.
- `scan_abort`, in, 1: level or pulse; forces a return to IDLE.
- `dbf_lut_addr`, out, `ADDR_WD`: LUT write address to the channels.
- `dbf_lut_we`, out, 1: LUT write enable to the channels.
- `tx_en`, out, 1: transmit window; channels treat `~tx_en` as input-valid.
- `start`, out, 1: beamforming enable to the channels.
- `smp_idx`, out, `SMP_WD`: receive sample index; drives the apodization/focus address.
- `line_idx`, out, `LINE_WD`: current scanline; selects the LUT source bank.
- `busy`, out, 1: high in every state except IDLE.
- `line_done`, out, 1: one-cycle pulse at the end of each line.
- `frame_done`, out, 1: one-cycle pulse at the end of the last line.

## Operation
- FSM states: IDLE, LOAD, TX, RX, NEXT. A single internal phase counter is cleared on every state entry.
- IDLE:
  - All outputs are 0.
  - `scan_go`=1 and `scan_abort`=0 → LOAD, with `line_idx`=0.
- LOAD:
  - `dbf_lut_we`=1.
  - `dbf_lut_addr` = phase counter, running 0..`LUT_DEPTH`-1 at one address per cycle.
  - After the write to `LUT_DEPTH`-1 → TX.
  - `dbf_lut_addr` returns to 0 whenever `dbf_lut_we`=0.
- TX: `tx_en`=1 for exactly `TX_CYC` cycles → RX.
- RX:
  - `start`=1 and `tx_en`=0.
  - `smp_idx` runs 0..`RX_SAMPLES`-1, one per cycle.
  - After the last sample → NEXT.
  - `smp_idx` is 0 outside RX.
- NEXT (one cycle):
  - `line_done`=1.
  - If `line_idx`==`NUM_LINES`-1: `frame_done`=1, `line_idx`←0, next state IDLE.
  - Otherwise: `line_idx`←`line_idx`+1, next state LOAD.
- Mutual exclusion: at most one of `dbf_lut_we`, `tx_en`, `start` is high in any cycle.
- `scan_abort`:
  - If high in any non-IDLE state, the next cycle is IDLE with all outputs 0 and `line_idx`=0.
  - No `line_done`/`frame_done` pulse is produced.
  - Abort during NEXT suppresses that cycle's transition; the done pulses already registered in that cycle stand.
- Collisions in IDLE: `scan_go` and `scan_abort` high together → stay IDLE (abort wins).
- `scan_go` while busy is ignored and is not queued.
- Counters saturate never; they wrap only through the explicit state transitions above.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Reset (`rst_n`=0, asynchronous) forces IDLE immediately: every output 0, `line_idx`=0, `smp_idx`=0, `dbf_lut_addr`=0.
- Reset release takes effect at the first clock edge with `rst_n`=1.
- `scan_go` sampled high at edge k → `busy`=1, `dbf_lut_we`=1, `dbf_lut_addr`=0 at edge k+1.
- Per-line length is `LUT_DEPTH` + `TX_CYC` + `RX_SAMPLES` + 1 cycles.
- Frame length from edge k+1 to `frame_done` inclusive is `NUM_LINES` × per-line length.
- The cycle after `frame_done`: `busy`=0. A `scan_go` in that cycle is accepted, so back-to-back frames have a 1-cycle IDLE gap.
- Transitions between active phases are gapless: the last `dbf_lut_we` cycle is immediately followed by the first `tx_en` cycle, and likewise TX→RX.

## Test plan
Parameters for all scenarios: `LUT_DEPTH`=4, `TX_CYC`=2, `RX_SAMPLES`=5, `NUM_LINES`=3.

1. **Single frame.** `scan_go` pulse at edge 0 → required response:
   - `dbf_lut_addr` 0,1,2,3 with `we` high on edges 1-4.
   - `tx_en` on edges 5-6.
   - `start` on edges 7-11 with `smp_idx` 0..4.
   - `line_done` on edge 12.
   - Repeats for lines 1 and 2; `frame_done` and the third `line_done` on edge 36; `busy`=0 on edge 37.
2. **Mid-RX abort.** `scan_abort` pulse during line 1 RX with `smp_idx`=2 → next edge: IDLE, all outputs 0, `line_idx`=0, no done pulses. A new `scan_go` then restarts at line 0.
3. **Input collisions.**
   - `scan_go` and `scan_abort` together in IDLE → remains IDLE, `busy`=0.
   - `scan_go` pulses during LOAD/TX/RX → no effect on the sequence or its timing.
4. **Mid-LOAD reset.** Assert `rst_n`=0 asynchronously with `dbf_lut_addr`=2 → all outputs 0 immediately, before the next clock edge. After release, IDLE until `scan_go`.
5. **Back-to-back frames.** `scan_go` on the cycle after `frame_done` → second frame starts with a 1-cycle gap, `line_idx` restarts at 0, and its `frame_done` occurs 36 cycles later.
6. **Exclusion assertion.** Across scenarios 1-5, `dbf_lut_we`+`tx_en`+`start` ≤ 1 every cycle, and `smp_idx`=0 whenever `start`=0.

Source files
------------

// File: rtl/dbf_scan_ctrl_if.sv
// dbf_scan_ctrl_if
// Bundles the scanline sequencer's control inputs and the signals it fans
// out to the DBF channel array and the apodization/summation stage.
//   scan_go, scan_abort         : frame start pulse / abort request
//   dbf_lut_addr, dbf_lut_we    : LUT write address and enable to channels
//   tx_en, start                : transmit window / beamforming enable
//   smp_idx, line_idx           : receive sample index / current scanline
//   busy, line_done, frame_done : status and end-of-line/frame pulses
// master: the sequencer. slave: whatever issues scan_go/scan_abort and
// consumes the outputs.
`timescale 1ns/1ps
interface dbf_scan_ctrl_if #(
  parameter int ADDR_WD = 8,
  parameter int SMP_WD  = 12,
  parameter int LINE_WD = 8
);
  logic               scan_go;
  logic               scan_abort;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic               tx_en;
  logic               start;
  logic [SMP_WD-1:0]  smp_idx;
  logic [LINE_WD-1:0] line_idx;
  logic               busy;
  logic               line_done;
  logic               frame_done;

  modport master (
    input  scan_go, scan_abort,
    output dbf_lut_addr, dbf_lut_we, tx_en, start, smp_idx, line_idx,
           busy, line_done, frame_done
  );

  modport slave (
    output scan_go, scan_abort,
    input  dbf_lut_addr, dbf_lut_we, tx_en, start, smp_idx, line_idx,
           busy, line_done, frame_done
  );
endinterface

// File: rtl/dbf_scan_ctrl.sv
// dbf_scan_ctrl
// Scanline sequencer for the DBF channel array. Per line: write the delay
// LUTs, hold the transmit window, then run the receive/beamforming window,
// then advance the line. Stops after NUM_LINES lines.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : dbf_scan_ctrl_if master modport (control in, channel/status out)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for scan_go, all outputs 0
// LOAD   | LUT write, dbf_lut_addr = 0..LUT_DEPTH-1
// TX     | tx_en high for TX_CYC cycles
// RX     | start high, smp_idx = 0..RX_SAMPLES-1
// NEXT   | one cycle, line_done (+ frame_done on last line), advance line
`timescale 1ns/1ps
module dbf_scan_ctrl #(
  parameter int ADDR_WD    = 8,
  parameter int LUT_DEPTH  = 256,
  parameter int TX_CYC     = 16,
  parameter int RX_SAMPLES = 2048,
  parameter int SMP_WD     = 12,
  parameter int NUM_LINES  = 128,
  parameter int LINE_WD    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dbf_scan_ctrl_if.master bus
);

  localparam int PH_MAX_A = (LUT_DEPTH > TX_CYC) ? LUT_DEPTH : TX_CYC;
  localparam int PH_MAX   = (PH_MAX_A > RX_SAMPLES) ? PH_MAX_A : RX_SAMPLES;
  // One spare bit keeps the width non-zero when every count is 1.
  localparam int PH_WD    = $clog2(PH_MAX) + 1;

  localparam logic [PH_WD-1:0]   LUT_LAST  = PH_WD'(LUT_DEPTH - 1);
  localparam logic [PH_WD-1:0]   TX_LAST   = PH_WD'(TX_CYC - 1);
  localparam logic [PH_WD-1:0]   RX_LAST   = PH_WD'(RX_SAMPLES - 1);
  localparam logic [LINE_WD-1:0] LINE_LAST = LINE_WD'(NUM_LINES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  logic [2:0]         state, nxt_state;
  logic [PH_WD-1:0]   phase, nxt_phase;
  logic [LINE_WD-1:0] line_q, nxt_line;

  always_comb begin
    nxt_state = state;
    nxt_phase = phase + 1'b1;
    nxt_line  = line_q;
    case (state)
      S_IDLE: begin
        nxt_phase = '0;
        nxt_line  = '0;
        if (bus.scan_go && !bus.scan_abort) nxt_state = S_LOAD;
      end
      S_LOAD: begin
        if (phase == LUT_LAST) begin
          nxt_state = S_TX;
          nxt_phase = '0;
        end
      end
      S_TX: begin
        if (phase == TX_LAST) begin
          nxt_state = S_RX;
          nxt_phase = '0;
        end
      end
      S_RX: begin
        if (phase == RX_LAST) begin
          nxt_state = S_NEXT;
          nxt_phase = '0;
        end
      end
      S_NEXT: begin
        nxt_phase = '0;
        if (line_q == LINE_LAST) begin
          nxt_state = S_IDLE;
          nxt_line  = '0;
        end else begin
          nxt_state = S_LOAD;
          nxt_line  = line_q + 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_phase = '0;
        nxt_line  = '0;
      end
    endcase
    // Abort overrides every transition, including the one out of NEXT.
    if (state != S_IDLE && bus.scan_abort) begin
      nxt_state = S_IDLE;
      nxt_phase = '0;
      nxt_line  = '0;
    end
  end

  // Outputs are decoded from the next-state values so each one comes
  // straight off a flop and lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      phase          <= '0;
      line_q         <= '0;
      bus.dbf_lut_we   <= 1'b0;
      bus.dbf_lut_addr <= '0;
      bus.tx_en        <= 1'b0;
      bus.start        <= 1'b0;
      bus.smp_idx      <= '0;
      bus.busy         <= 1'b0;
      bus.line_done    <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      state          <= nxt_state;
      phase          <= nxt_phase;
      line_q         <= nxt_line;
      bus.dbf_lut_we   <= (nxt_state == S_LOAD);
      bus.dbf_lut_addr <= (nxt_state == S_LOAD) ? ADDR_WD'(nxt_phase) : '0;
      bus.tx_en        <= (nxt_state == S_TX);
      bus.start        <= (nxt_state == S_RX);
      bus.smp_idx      <= (nxt_state == S_RX) ? SMP_WD'(nxt_phase) : '0;
      bus.busy         <= (nxt_state != S_IDLE);
      bus.line_done    <= (nxt_state == S_NEXT);
      bus.frame_done   <= (nxt_state == S_NEXT) && (nxt_line == LINE_LAST);
    end
  end

  assign bus.line_idx = line_q;

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
`timescale 1ns/1ps
module tb_dbf_scan_ctrl;
  localparam int ADDR_WD    = 8;
  localparam int LUT_DEPTH  = 4;
  localparam int TX_CYC     = 2;
  localparam int RX_SAMPLES = 5;
  localparam int SMP_WD     = 12;
  localparam int NUM_LINES  = 3;
  localparam int LINE_WD    = 8;
  localparam int LINE_LEN   = 12;  // 4 LOAD + 2 TX + 5 RX + 1 NEXT
  localparam int FRAME_LEN  = 36;

  typedef struct packed {
    logic               we;
    logic [ADDR_WD-1:0] addr;
    logic               tx;
    logic               st;
    logic [SMP_WD-1:0]  smp;
    logic [LINE_WD-1:0] line;
    logic               busy;
    logic               ld;
    logic               fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t act, expv;

  dbf_scan_ctrl_if #(.ADDR_WD(ADDR_WD), .SMP_WD(SMP_WD), .LINE_WD(LINE_WD)) bus ();

  dbf_scan_ctrl #(
    .ADDR_WD(ADDR_WD), .LUT_DEPTH(LUT_DEPTH), .TX_CYC(TX_CYC),
    .RX_SAMPLES(RX_SAMPLES), .SMP_WD(SMP_WD), .NUM_LINES(NUM_LINES),
    .LINE_WD(LINE_WD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t sample_vec();
    vec_t v;
    v.we   = bus.dbf_lut_we;
    v.addr = bus.dbf_lut_addr;
    v.tx   = bus.tx_en;
    v.st   = bus.start;
    v.smp  = bus.smp_idx;
    v.line = bus.line_idx;
    v.busy = bus.busy;
    v.ld   = bus.line_done;
    v.fd   = bus.frame_done;
    return v;
  endfunction

  // Expected outputs for cycle c (0 = first cycle after scan_go is taken).
  function automatic vec_t frame_vec(input int c);
    vec_t v;
    int ln, p;
    v    = '0;
    ln   = c / LINE_LEN;
    p    = c % LINE_LEN;
    v.busy = 1'b1;
    v.line = LINE_WD'(ln);
    if (p < 4) begin
      v.we = 1'b1; v.addr = ADDR_WD'(p);
    end else if (p < 6) begin
      v.tx = 1'b1;
    end else if (p < 11) begin
      v.st = 1'b1; v.smp = SMP_WD'(p - 6);
    end else begin
      v.ld = 1'b1; v.fd = (ln == 2);
    end
    return v;
  endfunction

  task automatic push_cycles(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(frame_vec(c));
  endtask

  // Monitor: every busy cycle consumes one expected vector; idle cycles must be all-zero.
  always @(negedge clk) begin
    act = sample_vec();
    checks++;
    if ((int'(act.we) + int'(act.tx) + int'(act.st)) > 1) begin
      errors++;
      $display("FAIL exclusion t=%0t: we=%b tx=%b start=%b, at most one allowed", $time, act.we, act.tx, act.st);
    end
    checks++;
    if (!act.st && act.smp != '0) begin
      errors++;
      $display("FAIL smp_idle t=%0t: smp_idx=%0d with start=0, expected 0", $time, act.smp);
    end
    if (act.busy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy t=%0t: got %h, expected idle", $time, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL seq t=%0t: got %h expected %h", $time, act, expv);
        end
      end
    end else begin
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL idle_zero t=%0t: got %h expected 0", $time, act);
      end
    end
  end

  task automatic pulse_go();
    bus.scan_go = 1'b1;
    @(posedge clk);
    #1 bus.scan_go = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL %s timeout: %0d expected vectors left, busy=%b, required 0/0", name, exp_q.size(), bus.busy);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    vec_t v;
    v = sample_vec();
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected 0", name, v);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.scan_go = 1'b0;
    bus.scan_abort = 1'b0;
    #2 check_zero("reset_state");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single frame
    push_cycles(FRAME_LEN);
    pulse_go();
    wait_drain("single_frame", 60);

    // go + abort together in IDLE
    bus.scan_go = 1'b1; bus.scan_abort = 1'b1;
    @(posedge clk);
    #1 bus.scan_go = 1'b0; bus.scan_abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL go_abort_idle: busy=%b expected 0", bus.busy);
    end
    repeat (2) @(posedge clk);
    #1;

    // Abort in line 1 RX at smp_idx=2 (cycle index 20)
    push_cycles(21);
    pulse_go();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.smp_idx !== SMP_WD'(2) || bus.line_idx !== LINE_WD'(1) || !bus.start) begin
      errors++;
      $display("FAIL abort_point: smp=%0d line=%0d start=%b expected 2/1/1", bus.smp_idx, bus.line_idx, bus.start);
    end
    bus.scan_abort = 1'b1;
    @(posedge clk);
    #1 bus.scan_abort = 1'b0;
    check_zero("after_abort");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_leftover: %0d vectors unconsumed, expected 0", exp_q.size());
      exp_q.delete();
    end

    // Restart at line 0 with stray scan_go pulses in LOAD, TX and RX
    push_cycles(FRAME_LEN);
    pulse_go();
    @(posedge clk);
    #1 pulse_go();
    repeat (2) @(posedge clk);
    #1 pulse_go();
    repeat (2) @(posedge clk);
    #1 pulse_go();
    n = 0;
    while (!bus.frame_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.frame_done) begin
      errors++;
      $display("FAIL frame_done_wait: frame_done=%b after %0d cycles, expected 1", bus.frame_done, n);
    end

    // Back-to-back: go in the idle cycle following frame_done
    push_cycles(FRAME_LEN);
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_busy: busy=%b expected 0", bus.busy);
    end
    pulse_go();
    wait_drain("back_to_back", 60);

    // Asynchronous reset during LOAD at dbf_lut_addr=2
    push_cycles(2);
    pulse_go();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.dbf_lut_addr !== ADDR_WD'(2) || !bus.dbf_lut_we) begin
      errors++;
      $display("FAIL load_addr2: addr=%0d we=%b expected 2/1", bus.dbf_lut_addr, bus.dbf_lut_we);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL post_reset_idle: left=%0d busy=%b expected 0/0", exp_q.size(), bus.busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
